// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default geometry,
// the loader FSM state encoding and a header-validation helper.
package imem_loader_pkg;

  // Default geometry: 32 words of 32 bits, 5-bit word address.
  localparam int DEPTH_DEF = 32;
  localparam int AW_DEF    = 5;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // A header byte is a usable word count when it is 1..depth.
  function automatic logic hdr_count_ok(input logic [7:0] n, input int depth);
    int n_int;
    n_int = int'({24'h0, n});
    return (n_int != 0) && (n_int <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream interface that feeds program bytes into the loader.
//
// Handshake: the source drives in_valid/in_data, the loader drives in_ready.
// A byte transfers on a rising clk edge where in_valid and in_ready are both
// high. The source must hold in_data stable while in_valid is high and the
// byte has not yet transferred; in_ready does not depend on in_valid.
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  // Byte source side.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  // Loader side.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/imem_ram.sv
// Instruction storage: one synchronous write port and one asynchronous read
// port. Contents are never cleared, so words survive resets and reloads.
module imem_ram
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write one assembled word on the edge the loader asks for it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read for the core's fetch path.
  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Program loader for a small instruction memory. A start pulse opens a load;
// the first streamed byte is the word count N, followed by 4*N bytes that are
// packed little-endian into 32-bit words and written to consecutive
// addresses. The core is held in reset until a full program is present.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                clk,
  input  logic                RN,
  input  logic                start,
  imem_loader_if.slave        bs,
  input  logic [31:0]         fetch_addr,
  output logic [31:0]         fetch_data,
  output logic                core_hold,
  output logic                done,
  output logic                err,
  output logic [AW:0]         words_loaded,
  output state_t              state_dbg
);

  localparam logic [AW:0] ONE_W = {{AW{1'b0}}, 1'b1};

  state_t        state;
  logic [1:0]    byte_cnt;      // byte position inside the word being built
  logic [23:0]   asm_q;         // first three bytes of the current word
  logic [AW:0]   n_words;       // word count taken from the header
  logic          in_ready_q;

  logic          accept;
  logic          word_we;
  logic [31:0]   word_wdata;
  logic [AW-1:0] word_waddr;
  logic [AW:0]   words_next;
  logic [31:0]   hdr_wide;
  logic [31:0]   ram_rdata;

  assign bs.in_ready = in_ready_q;
  assign state_dbg   = state;

  // A byte moves on this edge.
  assign accept      = bs.in_valid & in_ready_q;

  // The fourth byte of a word completes it; the three earlier bytes sit in
  // asm_q with the oldest byte in the low lane.
  assign word_we     = (state == ST_LOAD) && accept && (byte_cnt == 2'd3);
  assign word_wdata  = {bs.in_data, asm_q};
  assign word_waddr  = words_loaded[AW-1:0];
  assign words_next  = words_loaded + ONE_W;
  assign hdr_wide    = {24'h0, bs.in_data};

  // Loader FSM with registered status outputs; every transition sets the
  // outputs that belong to the destination state.
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      state        <= ST_IDLE;
      in_ready_q   <= 1'b0;
      core_hold    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      n_words      <= '0;
      byte_cnt     <= 2'd0;
      asm_q        <= 24'h0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // A new load restarts from a clean word counter and assembler.
          if (start) begin
            state        <= ST_HDR;
            in_ready_q   <= 1'b1;
            core_hold    <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            byte_cnt     <= 2'd0;
            asm_q        <= 24'h0;
          end
        end

        ST_HDR: begin
          if (accept) begin
            if (hdr_count_ok(bs.in_data, DEPTH)) begin
              state   <= ST_LOAD;
              n_words <= hdr_wide[AW:0];
            end else begin
              state      <= ST_ERR;
              in_ready_q <= 1'b0;
              err        <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (accept) begin
            if (byte_cnt == 2'd3) begin
              words_loaded <= words_next;
              byte_cnt     <= 2'd0;
              // Last word written: stop accepting and release the core.
              if (words_next == n_words) begin
                state      <= ST_DONE;
                in_ready_q <= 1'b0;
                core_hold  <= 1'b0;
                done       <= 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
              asm_q    <= {bs.in_data, asm_q[23:8]};
            end
          end
        end

        default: begin
          state      <= ST_IDLE;
          in_ready_q <= 1'b0;
          core_hold  <= 1'b1;
          done       <= 1'b0;
          err        <= 1'b0;
        end
      endcase
    end
  end

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (word_we),
    .waddr (word_waddr),
    .wdata (word_wdata),
    .raddr (fetch_addr[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Addresses past the memory read as zero instead of aliasing.
  assign fetch_data = (fetch_addr < 32'(DEPTH)) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed scenarios plus randomized loads, checked
// every cycle against a behavioural model of the loader.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic RN  = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic [31:0] fetch_data;
  logic        core_hold, done, err;
  logic [AW:0] words_loaded;
  state_t      state_dbg;

  imem_loader_if bs ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .RN           (RN),
    .start        (start),
    .bs           (bs),
    .fetch_addr   (fetch_addr),
    .fetch_data   (fetch_data),
    .core_hold    (core_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;
  logic rnd_fetch = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Flags describe what the loader is doing; bytes of the current word are
  // kept in a queue and packed only once four have arrived.
  logic       m_hdr = 1'b0, m_load = 1'b0, m_done = 1'b0, m_err = 1'b0;
  int         m_n = 0, m_cnt = 0;
  logic [7:0] m_bytes[$];
  logic [31:0] m_mem [DEPTH];
  logic       m_known [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
  end

  always @(posedge clk or negedge RN) begin
    if (!RN) begin
      m_hdr = 1'b0; m_load = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_cnt = 0;
      m_bytes.delete();
    end else if (start && !(m_hdr || m_load)) begin
      m_hdr = 1'b1; m_done = 1'b0; m_err = 1'b0;
      m_cnt = 0;
      m_bytes.delete();
    end else if (bs.in_valid && (m_hdr || m_load)) begin
      if (m_hdr) begin
        m_hdr = 1'b0;
        if (bs.in_data == 8'd0 || int'(bs.in_data) > DEPTH) m_err = 1'b1;
        else begin
          m_load = 1'b1;
          m_n = int'(bs.in_data);
        end
      end else begin
        m_bytes.push_back(bs.in_data);
        if (m_bytes.size() == 4) begin
          m_mem[m_cnt]   = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_known[m_cnt] = 1'b1;
          m_cnt++;
          m_bytes.delete();
          if (m_cnt == m_n) begin
            m_load = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end
  end

  function automatic state_t model_state();
    if (m_hdr)  return ST_HDR;
    if (m_load) return ST_LOAD;
    if (m_done) return ST_DONE;
    if (m_err)  return ST_ERR;
    return ST_IDLE;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", {31'h0, bs.in_ready}, {31'h0, (m_hdr | m_load)});
      check("core_hold", {31'h0, core_hold}, {31'h0, ~m_done});
      check("done", {31'h0, done}, {31'h0, m_done});
      check("err", {31'h0, err}, {31'h0, m_err});
      check("words_loaded", {26'h0, words_loaded}, 32'(m_cnt));
      check("state_dbg", {29'h0, state_dbg}, {29'h0, model_state()});
      if (fetch_addr >= 32'(DEPTH)) check("fetch_oor", fetch_data, 32'h0);
      else if (m_known[fetch_addr[AW-1:0]])
        check("fetch_data", fetch_data, m_mem[fetch_addr[AW-1:0]]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #2;
    if (rnd_fetch)
      fetch_addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 35));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Offer one byte and hold it until it transfers.
  task automatic send_byte(input logic [7:0] b);
    logic r;
    logic sent;
    sent = 1'b0;
    bs.in_valid = 1'b1;
    bs.in_data  = b;
    for (int k = 0; k < 50 && !sent; k++) begin
      r = bs.in_ready;
      cycle();
      if (r) sent = 1'b1;
    end
    bs.in_valid = 1'b0;
    if (!sent) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles", b);
    end
  endtask

  task automatic gap();
    bs.in_valid = 1'b0;
    bs.in_data  = 8'($urandom);
    cycle();
  endtask

  task automatic do_reset();
    RN = 1'b0;
    cycle();
    cycle();
    RN = 1'b1;
    cycle();
  endtask

  task automatic check_fetch(input logic [31:0] addr, input string name);
    logic [31:0] e;
    fetch_addr = addr;
    #1;
    e = exp_q.pop_front();
    check(name, fetch_data, e);
  endtask

  // Watchdog: the run must always reach its summary.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int sel;
    bit aborted;
    bs.in_valid = 1'b0;
    bs.in_data  = 8'h00;
    #1 RN = 1'b0;
    #1 chk_en = 1'b1;
    cycle();
    cycle();
    // reset values
    check("rst_core_hold", {31'h0, core_hold}, 32'h1);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_words", {26'h0, words_loaded}, 32'h0);
    RN = 1'b1;
    cycle();

    // single-word program
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h83); send_byte(8'h20); send_byte(8'h02);
    check("one_done", {31'h0, done}, 32'h1);
    check("one_core_hold", {31'h0, core_hold}, 32'h0);
    check("one_words", {26'h0, words_loaded}, 32'h1);
    exp_q.push_back(32'h02208300);
    check_fetch(32'd0, "one_word0");
    check("model_pin_w0", m_mem[0], 32'h02208300);

    // two words with in_valid toggling every cycle
    pulse_start();
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) begin
      gap();
      if (i == 7) check("tog_not_done", {31'h0, done}, 32'h0);
      send_byte(8'(8'h11 * (i + 1)));
    end
    check("tog_done", {31'h0, done}, 32'h1);
    exp_q.push_back(32'h44332211);
    exp_q.push_back(32'h88776655);
    check_fetch(32'd0, "tog_word0");
    check_fetch(32'd1, "tog_word1");

    // bad headers
    pulse_start();
    send_byte(8'h00);
    check("hdr0_err", {31'h0, err}, 32'h1);
    check("hdr0_ready", {31'h0, bs.in_ready}, 32'h0);
    check("hdr0_hold", {31'h0, core_hold}, 32'h1);
    pulse_start();
    check("hdr0_restart_err", {31'h0, err}, 32'h0);
    check("hdr0_restart_ready", {31'h0, bs.in_ready}, 32'h1);
    send_byte(8'h21);
    check("hdr21_err", {31'h0, err}, 32'h1);
    check("hdr21_ready", {31'h0, bs.in_ready}, 32'h0);

    // reset in the middle of a word
    pulse_start();
    send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'hEE); send_byte(8'hFF);
    do_reset();
    check("abort_hold", {31'h0, core_hold}, 32'h1);
    check("abort_state", {29'h0, state_dbg}, {29'h0, ST_IDLE});
    exp_q.push_back(32'hDDCCBBAA);
    exp_q.push_back(32'h88776655);
    check_fetch(32'd0, "abort_word0");
    check_fetch(32'd1, "abort_word1");
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("fresh_done", {31'h0, done}, 32'h1);
    exp_q.push_back(32'h04030201);
    check_fetch(32'd0, "fresh_word0");

    // out-of-range fetch
    exp_q.push_back(32'h0);
    check_fetch(32'd32, "fetch_32");
    exp_q.push_back(32'h0);
    check_fetch(32'hFFFF_FFFF, "fetch_ffffffff");

    // start during LOAD is ignored; start in DONE reopens the header
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    pulse_start();
    check("start_in_load_ready", {31'h0, bs.in_ready}, 32'h1);
    send_byte(8'h40); send_byte(8'h50); send_byte(8'h60); send_byte(8'h70); send_byte(8'h80);
    check("ign_done", {31'h0, done}, 32'h1);
    exp_q.push_back(32'h40302010);
    exp_q.push_back(32'h80706050);
    check_fetch(32'd0, "ign_word0");
    check_fetch(32'd1, "ign_word1");
    // extra bytes after completion must not be taken
    bs.in_valid = 1'b1; bs.in_data = 8'h99;
    cycle(); cycle();
    bs.in_valid = 1'b0;
    check("extra_words", {26'h0, words_loaded}, 32'h2);
    pulse_start();
    check("redo_hold", {31'h0, core_hold}, 32'h1);
    check("redo_ready", {31'h0, bs.in_ready}, 32'h1);
    send_byte(8'h21);   // leaves the loader in ERR

    // randomized loads
    rnd_fetch = 1'b1;
    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(0, 9);
      aborted = 1'b0;
      pulse_start();
      if (sel == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 255);
        send_byte(8'(n));
        gap();
        continue;
      end
      n = (t == 4 || t == 17) ? 32 : $urandom_range(1, 6);
      send_byte(8'(n));
      for (int b = 0; b < 4 * n && !aborted; b++) begin
        if ($urandom_range(0, 2) == 0) gap();
        if ($urandom_range(0, 19) == 0) pulse_start();
        if (sel == 1 && b == 4 * n - 2) begin
          do_reset();
          aborted = 1'b1;
        end else begin
          send_byte(8'($urandom));
        end
      end
      if (!aborted) begin
        bs.in_valid = 1'b1; bs.in_data = 8'($urandom);
        cycle(); cycle();
        bs.in_valid = 1'b0;
      end
      gap();
    end
    rnd_fetch = 1'b0;
    cycle();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
